wash_cycle_sequencer: RTL

Top-level washing-machine cycle controller that sits on the consumer side of the phase-timer interface. It drives one enable per phase timer and consumes that timer's done and done_pre pulses. It steps through FILL, WASH, RINSE and SPIN, and drives the valve, motor, drain and door-lock outputs. Pause and door-open stall the active timer without losing a done event.

---
 rtl/wash_cycle_sequencer_if.sv | 43 ++++
 rtl/wash_cycle_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/wash_cycle_sequencer_if.sv
// Bundle of control, timer and actuator signals for the wash cycle sequencer.
// DOUBLE_WASH_EN adds the double_wash request input.
interface wash_cycle_sequencer_if;
  logic       start;
  logic       pause;
  logic       door_open;
`ifdef DOUBLE_WASH_EN
  logic       double_wash;
`endif
  logic [3:0] tmr_done;
  logic [3:0] tmr_done_pre;
  logic [3:0] tmr_en;
  logic       valve;
  logic [1:0] motor;
  logic       drain;
  logic       door_lock;
  logic       busy;
  logic       warn;
  logic       door_alarm;
  logic       cycle_done;
  logic [2:0] dbg_state;

  // Handshake: tmr_en[i] is a level request to phase timer i; the timer answers
  // with a single-cycle tmr_done[i] pulse that is consumed whether or not
  // tmr_en[i] is still high in that cycle.
  modport master (
`ifdef DOUBLE_WASH_EN
    input  double_wash,
`endif
    input  start, pause, door_open, tmr_done, tmr_done_pre,
    output tmr_en, valve, motor, drain, door_lock, busy, warn, door_alarm,
    output cycle_done, dbg_state
  );

  modport slave (
`ifdef DOUBLE_WASH_EN
    output double_wash,
`endif
    output start, pause, door_open, tmr_done, tmr_done_pre,
    input  tmr_en, valve, motor, drain, door_lock, busy, warn, door_alarm,
    input  cycle_done, dbg_state
  );
endinterface

// File: rtl/wash_cycle_sequencer.sv
// Washing-machine cycle controller: FILL -> WASH -> RINSE(xN) -> SPIN -> DONE.
// Defining DOUBLE_WASH_EN adds a latched double_wash request for two WASH passes.
module wash_cycle_sequencer #(
  parameter int RINSE_REPEAT = 1,
  parameter int DONE_CYCLES  = 4
) (
  input logic                    clk,
  input logic                    rst,
  wash_cycle_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WASH  = 3'd2,
    S_RINSE = 3'd3,
    S_SPIN  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] rinse_cnt_q, rinse_cnt_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;

  logic       valve_q, valve_d;
  logic [1:0] motor_q, motor_d;
  logic       drain_q, drain_d;
  logic       lock_q, lock_d;
  logic       busy_q, busy_d;
  logic       cdone_q, cdone_d;

`ifdef DOUBLE_WASH_EN
  logic       dw_q, dw_d;
  logic       pass_q, pass_d;
`endif

  logic       stall;
  logic [3:0] phase_oh;

  assign stall = bus.pause | bus.door_open;

  // Active phase select; zero outside the four run states.
  always_comb begin
    phase_oh = 4'b0000;
    case (state_q)
      S_FILL:  phase_oh = 4'b0001;
      S_WASH:  phase_oh = 4'b0010;
      S_RINSE: phase_oh = 4'b0100;
      S_SPIN:  phase_oh = 4'b1000;
      default: phase_oh = 4'b0000;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rinse_cnt_d = rinse_cnt_q;
    hold_cnt_d  = hold_cnt_q;
`ifdef DOUBLE_WASH_EN
    dw_d        = dw_q;
    pass_d      = pass_q;
`endif
    case (state_q)
      S_IDLE: begin
        rinse_cnt_d = 3'd0;
        hold_cnt_d  = 4'd0;
        if (bus.start && !bus.door_open) begin
          state_d = S_FILL;
`ifdef DOUBLE_WASH_EN
          dw_d    = bus.double_wash;
          pass_d  = 1'b0;
`endif
        end
      end
      S_FILL: if (bus.tmr_done[0]) state_d = S_WASH;
      S_WASH: begin
        if (bus.tmr_done[1]) begin
`ifdef DOUBLE_WASH_EN
          if (dw_q && !pass_q) pass_d  = 1'b1;
          else                 state_d = S_RINSE;
`else
          state_d = S_RINSE;
`endif
        end
      end
      S_RINSE: begin
        // The rinse timer self-restarts, so extra passes just stay put.
        if (bus.tmr_done[2]) begin
          if (rinse_cnt_q == 3'(RINSE_REPEAT - 1)) state_d = S_SPIN;
          else rinse_cnt_d = rinse_cnt_q + 3'd1;
        end
      end
      S_SPIN: begin
        if (bus.tmr_done[3]) begin
          state_d    = S_DONE;
          hold_cnt_d = 4'd0;
        end
      end
      S_DONE: begin
        if (hold_cnt_q == 4'(DONE_CYCLES - 1)) begin
          state_d    = S_IDLE;
          hold_cnt_d = 4'd0;
        end else begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the next state so they line up with state_q.
  always_comb begin
    valve_d = 1'b0;
    motor_d = 2'b00;
    drain_d = 1'b0;
    lock_d  = 1'b0;
    busy_d  = 1'b0;
    cdone_d = 1'b0;
    case (state_d)
      S_FILL:  begin valve_d = 1'b1; lock_d = 1'b1; busy_d = 1'b1; end
      S_WASH:  begin motor_d = 2'b01; lock_d = 1'b1; busy_d = 1'b1; end
      S_RINSE: begin valve_d = 1'b1; motor_d = 2'b01; lock_d = 1'b1; busy_d = 1'b1; end
      S_SPIN:  begin motor_d = 2'b10; drain_d = 1'b1; lock_d = 1'b1; busy_d = 1'b1; end
      S_DONE:  cdone_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rinse_cnt_q <= 3'd0;
      hold_cnt_q  <= 4'd0;
      valve_q     <= 1'b0;
      motor_q     <= 2'b00;
      drain_q     <= 1'b0;
      lock_q      <= 1'b0;
      busy_q      <= 1'b0;
      cdone_q     <= 1'b0;
`ifdef DOUBLE_WASH_EN
      dw_q        <= 1'b0;
      pass_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rinse_cnt_q <= rinse_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      valve_q     <= valve_d;
      motor_q     <= motor_d;
      drain_q     <= drain_d;
      lock_q      <= lock_d;
      busy_q      <= busy_d;
      cdone_q     <= cdone_d;
`ifdef DOUBLE_WASH_EN
      dw_q        <= dw_d;
      pass_q      <= pass_d;
`endif
    end
  end

  // Water and motor cut out immediately on a stall; lock and drain hold.
  assign bus.tmr_en     = stall ? 4'b0000 : phase_oh;
  assign bus.valve      = valve_q & ~stall;
  assign bus.motor      = motor_q & {2{~stall}};
  assign bus.drain      = drain_q;
  assign bus.door_lock  = lock_q;
  assign bus.busy       = busy_q;
  assign bus.cycle_done = cdone_q;
  assign bus.warn       = (|(bus.tmr_done_pre & phase_oh)) & ~stall;
  assign bus.door_alarm = bus.door_open & (|phase_oh);
  assign bus.dbg_state  = state_q;

endmodule
